// File: rtl/yadmc_wb_arbiter_if.sv
// rtl/yadmc_wb_arbiter_if.sv - Wishbone bundle between the masters, the arbiter and the yadmc slave port
interface yadmc_wb_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    // master side, packed 32/4 bits per master, master k in the k-th slice
    logic [32*NUM_MASTERS-1:0] m_adr_i;
    logic [32*NUM_MASTERS-1:0] m_dat_i;
    logic [4*NUM_MASTERS-1:0]  m_sel_i;
    logic [NUM_MASTERS-1:0]    m_cyc_i;
    logic [NUM_MASTERS-1:0]    m_stb_i;
    logic [NUM_MASTERS-1:0]    m_we_i;
    logic [31:0]               m_dat_o;
    logic [NUM_MASTERS-1:0]    m_ack_o;
    logic [NUM_MASTERS-1:0]    m_err_o;
    // yadmc slave port
    logic [31:0]               s_adr_o;
    logic [31:0]               s_dat_o;
    logic [3:0]                s_sel_o;
    logic                      s_cyc_o;
    logic                      s_stb_o;
    logic                      s_we_o;
    logic [31:0]               s_dat_i;
    logic                      s_ack_i;

    // arbiter view: it masters the yadmc port on behalf of the owner
    modport master (
        input  m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o
    );

    // environment view: requesting masters plus the yadmc slave
    modport slave (
        output m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o
    );
endinterface

// File: rtl/yadmc_wb_arbiter.sv
// rtl/yadmc_wb_arbiter.sv - round-robin Wishbone arbiter for the yadmc slave port (optional watchdog: YADMC_ARB_TIMEOUT_EN)
module yadmc_wb_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    yadmc_wb_arbiter_if.master     bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   busy_o
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef YADMC_ARB_TIMEOUT_EN
        ST_ABORT = 2'd2,
`endif
        ST_OWN   = 2'd1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          ptr_q, ptr_d;

    logic [IW-1:0]          win_idx;
    logic                   win_found;
    int                     scan_idx;

    logic                   own_active;
    logic                   owner_cyc;
    logic                   owner_stb;
    logic                   owner_we;
    logic [31:0]            mux_adr;
    logic [31:0]            mux_dat;
    logic [3:0]             mux_sel;

    // only the OWN state drives the slave; ABORT keeps the grant but silences the bus
    assign own_active = (state_q == ST_OWN);
    assign owner_cyc  = |(grant_q & bus.m_cyc_i);
    assign owner_stb  = |(grant_q & bus.m_stb_i);
    assign owner_we   = |(grant_q & bus.m_we_i);

    // round-robin scan starting one past the last winner
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        scan_idx  = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            scan_idx = (int'(ptr_q) + k) % NUM_MASTERS;
            if (!win_found && bus.m_cyc_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(scan_idx);
            end
        end
    end

    // AND-OR mux of the owner's request fields, selected by the registered grant
    always_comb begin
        mux_adr = '0;
        mux_dat = '0;
        mux_sel = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                mux_adr = mux_adr | bus.m_adr_i[32*k +: 32];
                mux_dat = mux_dat | bus.m_dat_i[32*k +: 32];
                mux_sel = mux_sel | bus.m_sel_i[4*k +: 4];
            end
        end
    end

    assign bus.s_adr_o = mux_adr;
    assign bus.s_dat_o = mux_dat;
    assign bus.s_sel_o = mux_sel;
    assign bus.s_cyc_o = own_active & owner_cyc;
    assign bus.s_stb_o = own_active & owner_stb;
    assign bus.s_we_o  = own_active & owner_we;
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_ack_o = (own_active && bus.s_ack_i) ? grant_q : '0;
    assign grant_o     = grant_q;
    assign busy_o      = |grant_q;

`ifdef YADMC_ARB_TIMEOUT_EN
    logic [15:0]            cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] err_q, err_d;
    logic                   timeout_hit;

    // the stalled-cycle count would reach the limit at this edge while the owner still holds cyc
    assign timeout_hit = own_active && owner_cyc && bus.s_stb_o && !bus.s_ack_i &&
                         (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));

    // watchdog count of stalled strobe cycles, cleared by any ack and outside ownership
    always_comb begin
        cnt_d = cnt_q;
        err_d = timeout_hit ? grant_q : '0;
        if (!own_active || bus.s_ack_i) begin
            cnt_d = '0;
        end else if (bus.s_stb_o) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // watchdog registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.m_err_o = err_q;
`else
    assign bus.m_err_o = '0;
`endif

    // ownership FSM: grant on request, hold while owner cyc is high, release otherwise
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d          = ST_OWN;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    ptr_d            = win_idx;
                end
            end
            ST_OWN: begin
                if (!owner_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
`ifdef YADMC_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (!owner_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // state, grant and round-robin pointer; master 0 wins first after reset
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_yadmc_wb_arbiter.sv
// tb/tb_yadmc_wb_arbiter.sv - self-checking bench for yadmc_wb_arbiter
module tb_yadmc_wb_arbiter;
    localparam int N  = 3;
    localparam int TO = 16;

    logic         sys_clk;
    logic         sys_rst_n;
    logic [N-1:0] grant_o;
    logic         busy_o;

    yadmc_wb_arbiter_if #(.NUM_MASTERS(N)) bus ();

    yadmc_wb_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus),
        .grant_o   (grant_o),
        .busy_o    (busy_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_req(input logic [N-1:0] cyc, input logic [N-1:0] stb, input logic ack);
        bus.m_cyc_i = cyc;
        bus.m_stb_i = stb;
        bus.s_ack_i = ack;
    endtask

    task automatic do_reset();
        sys_rst_n   = 1'b0;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.s_ack_i = 1'b0;
        bus.s_dat_i = '0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    // reference model: owner index (-1 when idle), last winner, watchdog state
    int m_owner, m_ptr, m_wait, m_err;
    bit m_abort;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_wait  = 0;
        m_err   = -1;
        m_abort = 1'b0;
    endtask

    task automatic model_edge();
        int new_err;
        new_err = -1;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && bus.m_cyc_i[c]) begin
                    m_owner = c;
                    m_ptr   = c;
                    m_wait  = 0;
                end
            end
        end else if (!bus.m_cyc_i[m_owner]) begin
            m_owner = -1;
            m_abort = 1'b0;
        end else if (!m_abort) begin
`ifdef YADMC_ARB_TIMEOUT_EN
            if (bus.s_ack_i) m_wait = 0;
            else if (bus.m_stb_i[m_owner]) begin
                m_wait++;
                if (m_wait == TO) begin
                    m_abort = 1'b1;
                    new_err = m_owner;
                end
            end
`endif
        end
        m_err = new_err;
    endtask

    typedef struct {
        logic [N-1:0] cyc;
        logic [N-1:0] stb;
        logic         ack;
        logic [N-1:0] exp_grant;
        logic         exp_scyc;
        logic         exp_sstb;
        logic [N-1:0] exp_ack;
    } vec_t;

    vec_t vecs[14];
    logic [31:0] sdram [logic [31:0]];
    logic [N-1:0] seq[$];
    logic [N-1:0] exp_seq[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] g, prev, drop, cycr, exp_g, exp_a, exp_e;
        logic [31:0]  radr[N];
        logic         active;
        int           cnt;

        // cyc, stb, ack | grant, s_cyc, s_stb, m_ack  (starts from reset, pointer at N-1)
        vecs[0]  = '{3'b011, 3'b011, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[1]  = '{3'b011, 3'b011, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001};
        vecs[2]  = '{3'b010, 3'b010, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000};
        vecs[3]  = '{3'b010, 3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[4]  = '{3'b010, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000};
        vecs[5]  = '{3'b110, 3'b110, 1'b1, 3'b010, 1'b1, 1'b1, 3'b010};
        vecs[6]  = '{3'b110, 3'b100, 1'b0, 3'b010, 1'b1, 1'b0, 3'b000};
        vecs[7]  = '{3'b100, 3'b100, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000};
        vecs[8]  = '{3'b100, 3'b100, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[9]  = '{3'b101, 3'b101, 1'b1, 3'b100, 1'b1, 1'b1, 3'b100};
        vecs[10] = '{3'b001, 3'b001, 1'b0, 3'b100, 1'b0, 1'b0, 3'b000};
        vecs[11] = '{3'b001, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
        vecs[12] = '{3'b000, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000};
        vecs[13] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
        exp_seq  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        for (int k = 0; k < N; k++) begin
            bus.m_adr_i[32*k +: 32] = 32'h1000_0000 + k;
            bus.m_dat_i[32*k +: 32] = 32'h5000_0000 + k;
            bus.m_sel_i[4*k +: 4]   = 4'h3;
        end
        sys_rst_n   = 1'b0;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.s_ack_i = 1'b0;
        bus.s_dat_i = '0;
        #12;
        chk("reset grant", 32'(grant_o), 0);
        chk("reset busy", 32'(busy_o), 0);
        chk("reset s_cyc/stb/we", {29'd0, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}, 0);
        chk("reset m_ack", 32'(bus.m_ack_o), 0);
        chk("reset m_err", 32'(bus.m_err_o), 0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // handover, dead cycle, lock, rotation
        for (int i = 0; i < 14; i++) begin
            set_req(vecs[i].cyc, vecs[i].stb, vecs[i].ack);
            #1;
            chk($sformatf("vec%0d grant", i), 32'(grant_o), 32'(vecs[i].exp_grant));
            chk($sformatf("vec%0d s_cyc", i), 32'(bus.s_cyc_o), 32'(vecs[i].exp_scyc));
            chk($sformatf("vec%0d s_stb", i), 32'(bus.s_stb_o), 32'(vecs[i].exp_sstb));
            chk($sformatf("vec%0d m_ack", i), 32'(bus.m_ack_o), 32'(vecs[i].exp_ack));
            step();
        end

        // master0 write then readback through a tiny SDRAM model
        bus.m_adr_i[31:0] = 32'h0004_4000;
        bus.m_dat_i[31:0] = 32'hcafe_babe;
        bus.m_sel_i[3:0]  = 4'hf;
        bus.m_we_i        = 3'b001;
        set_req(3'b001, 3'b001, 1'b0);
        #1;
        chk("wr s_cyc before grant", 32'(bus.s_cyc_o), 0);
        step();
        chk("wr s_cyc", 32'(bus.s_cyc_o), 1);
        chk("wr s_adr", bus.s_adr_o, 32'h0004_4000);
        chk("wr s_dat", bus.s_dat_o, 32'hcafe_babe);
        chk("wr s_sel/we", {27'd0, bus.s_sel_o, bus.s_we_o}, 32'h1f);
        bus.s_ack_i = 1'b1;
        #1;
        chk("wr m_ack", 32'(bus.m_ack_o), 32'b001);
        if (bus.s_cyc_o && bus.s_we_o) sdram[bus.s_adr_o] = bus.s_dat_o;
        step();
        set_req(3'b000, 3'b000, 1'b0);
        step();
        bus.m_we_i = 3'b000;
        set_req(3'b001, 3'b001, 1'b0);
        step();
        bus.s_dat_i = sdram.exists(bus.s_adr_o) ? sdram[bus.s_adr_o] : 32'hdead_dead;
        bus.s_ack_i = 1'b1;
        #1;
        chk("rd m_dat", bus.m_dat_o, 32'hcafe_babe);
        chk("rd m_ack", 32'(bus.m_ack_o), 32'b001);
        step();
        set_req(3'b000, 3'b000, 1'b0);
        step();

        // asynchronous reset in the middle of a master1 write
        bus.m_we_i = 3'b010;
        set_req(3'b010, 3'b010, 1'b0);
        step();
        chk("pre-reset grant", 32'(grant_o), 32'b010);
        bus.s_ack_i = 1'b1;
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async rst s_cyc", 32'(bus.s_cyc_o), 0);
        chk("async rst grant", 32'(grant_o), 0);
        chk("async rst m_ack", 32'(bus.m_ack_o), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        bus.m_we_i = 3'b000;
        set_req(3'b011, 3'b011, 1'b0);
        step();
        chk("post-reset grant", 32'(grant_o), 32'b001);

        // continuous one-access requesters rotate 001,010,100,...
        do_reset();
        drop = '0;
        prev = '0;
        seq.delete();
        for (int c = 0; c < 60 && seq.size() < 6; c++) begin
            set_req(~drop, ~drop, 1'b1);
            #1;
            g = grant_o;
            if (g != prev && g != '0) seq.push_back(g);
            prev = g;
            drop = g;
            step();
        end
        chk("rotation count", 32'(seq.size()), 6);
        for (int i = 0; i < 6 && i < seq.size(); i++)
            chk($sformatf("rotation %0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        set_req(3'b000, 3'b000, 1'b0);
        step();

`ifdef YADMC_ARB_TIMEOUT_EN
        // slave never acks: error pulse once the limit is reached, late ack swallowed
        do_reset();
        set_req(3'b001, 3'b001, 1'b0);
        step();
        cnt = 0;
        for (int i = 1; i <= TO; i++) begin
            #1;
            if (bus.m_err_o == '0 && bus.s_cyc_o) cnt++;
            step();
        end
        chk("timeout quiet stb cycles", 32'(cnt), 32'(TO));
        chk("timeout m_err", 32'(bus.m_err_o), 32'b001);
        chk("timeout s_cyc", 32'(bus.s_cyc_o), 0);
        chk("timeout s_stb", 32'(bus.s_stb_o), 0);
        bus.s_ack_i = 1'b1;
        #1;
        chk("abort late ack", 32'(bus.m_ack_o), 0);
        step();
        chk("err one cycle", 32'(bus.m_err_o), 0);
        chk("abort holds grant", 32'(grant_o), 32'b001);
        set_req(3'b000, 3'b000, 1'b0);
        step();
        chk("abort release", 32'(grant_o), 0);
`endif

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        cycr = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) cycr[k] = ~cycr[k];
                radr[k] = $urandom;
                bus.m_adr_i[32*k +: 32] = radr[k];
            end
            bus.m_cyc_i = cycr;
            bus.m_stb_i = N'($urandom);
            bus.m_we_i  = N'($urandom);
            bus.s_ack_i = 1'($urandom);
            bus.s_dat_i = $urandom;
            #1;
            active = (m_owner >= 0) && !m_abort;
            exp_g  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            exp_a  = (active && bus.s_ack_i) ? exp_g : '0;
            exp_e  = (m_err >= 0) ? N'(1 << m_err) : '0;
            chk("rnd grant", 32'(grant_o), 32'(exp_g));
            chk("rnd busy", 32'(busy_o), 32'(m_owner >= 0));
            chk("rnd s_cyc", 32'(bus.s_cyc_o), 32'(active && bus.m_cyc_i[m_owner]));
            chk("rnd s_stb", 32'(bus.s_stb_o), 32'(active && bus.m_stb_i[m_owner]));
            chk("rnd m_ack", 32'(bus.m_ack_o), 32'(exp_a));
            chk("rnd m_err", 32'(bus.m_err_o), 32'(exp_e));
            chk("rnd m_dat", bus.m_dat_o, bus.s_dat_i);
            if (m_owner >= 0) chk("rnd s_adr", bus.s_adr_o, radr[m_owner]);
            @(posedge sys_clk);
            model_edge();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
